// File: rtl/mem_access_pkg.sv
// Shared types and byte-enable constants for the load/store unit.
// Optional build macro MISALIGN_TRAP_EN enables the misaligned-access trap.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    RESP = 2'b11
  } mau_state_t;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  // Size code 2'b11 is reserved and behaves as a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_HALF: mis = addr_lo[0];
      SZ_BYTE: mis = 1'b0;
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational byte-lane steering: store byte enables / lane replication and
// load extraction with sign or zero extension.
module lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

  // Select lane pattern and extension by access size.
  always_comb begin
    be        = BE_WORD;
    wdata_rep = wdata;
    rdata_ext = rdata;
    case (size)
      SZ_HALF: begin
        be        = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{~uns & half_sel[15]}}, half_sel};
      end
      SZ_BYTE: begin
        be        = BE_BYTE0 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{~uns & byte_sel[7]}}, byte_sel};
      end
      default: begin
        be        = BE_WORD;
        wdata_rep = wdata;
        rdata_ext = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator between the MEM stage and a req/gnt/rvalid data port.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses without a bus request.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          stall,
  output logic          misalign,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
);

  mau_state_t    state_q, state_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic [3:0]    be_s;
  logic [DW-1:0] wdata_rep_s;
  logic [DW-1:0] rdata_ext_s;

  lane_align u_lane_align (
    .size      (size_q),
    .addr_lo   (addr_q[1:0]),
    .uns       (uns_q),
    .wdata     (wdata_q),
    .rdata     (mem_rdata),
    .be        (be_s),
    .wdata_rep (wdata_rep_s),
    .rdata_ext (rdata_ext_s)
  );

`ifdef MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
`endif

  // Next-state and capture logic.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef MISALIGN_TRAP_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = {DW{1'b0}};
`ifdef MISALIGN_TRAP_EN
          // A trapped access completes without touching the bus.
          if (is_misaligned(req_size, req_addr[1:0])) begin
            state_d    = RESP;
            misalign_d = 1'b1;
          end else begin
            state_d    = REQ;
            misalign_d = 1'b0;
          end
`else
          state_d = REQ;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          if (we_q) begin
            state_d = RESP;
          end else if (mem_rvalid) begin
            rdata_d = rdata_ext_s;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          rdata_d = rdata_ext_s;
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        state_d = IDLE;
`ifdef MISALIGN_TRAP_EN
        misalign_d = 1'b0;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and request capture registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= {AW{1'b0}};
      wdata_q <= {DW{1'b0}};
      rdata_q <= {DW{1'b0}};
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  // Misalign flag, set only while the trapped response is presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  // Bus outputs are gated by the REQ state so they read zero at rest.
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign stall     = ((state_q == IDLE) & req_valid) | (state_q == REQ) | (state_q == WAIT);
  assign mem_req   = (state_q == REQ);
  assign mem_we    = mem_req & we_q;
  assign mem_be    = mem_req ? be_s : 4'b0000;
  assign mem_addr  = mem_req ? {addr_q[AW-1:2], 2'b00} : {AW{1'b0}};
  assign mem_wdata = mem_req ? wdata_rep_s : {DW{1'b0}};

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed accesses push expected
// responses; a monitor pops and compares on every rsp_valid.
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        stall;
  logic        misalign;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  mem_access_unit dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .stall        (stall),
    .misalign     (misalign),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_be       (mem_be),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
  } rsp_t;

  rsp_t sb_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   rsp_seen = 0;
  int   rsp_expected = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      rsp_t e;
      rsp_seen++;
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_misalign", {31'd0, misalign}, {31'd0, e.mis});
      end
    end
  end

  task automatic check_bus(input logic we, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wdata);
    chk("mem_req", {31'd0, mem_req}, 32'd1);
    chk("mem_we", {31'd0, mem_we}, {31'd0, we});
    chk("mem_be", {28'd0, mem_be}, {28'd0, be});
    chk("mem_addr", mem_addr, addr);
    chk("mem_wdata", mem_wdata, wdata);
    chk("stall_req", {31'd0, stall}, 32'd1);
  endtask

  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int gnt_dly, input int rv_gap, input logic [31:0] rdata,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_rdata);
    logic [31:0] exp_addr;
    rsp_t e;
    exp_addr = {addr[31:2], 2'b00};
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    chk("stall_idle_valid", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    e.rdata = we ? 32'd0 : exp_rdata;
    e.mis = 1'b0;
    sb_q.push_back(e);
    rsp_expected++;
    for (int i = 0; i < gnt_dly; i++) begin
      @(negedge clk);
      check_bus(we, exp_be, exp_addr, exp_wdata);
      @(posedge clk); #1;
    end
    mem_gnt = 1'b1;
    if (!we && rv_gap == 0) begin
      mem_rvalid = 1'b1;
      mem_rdata = rdata;
    end
    @(negedge clk);
    check_bus(we, exp_be, exp_addr, exp_wdata);
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    if (!we && rv_gap > 0) begin
      for (int i = 1; i < rv_gap; i++) begin
        @(negedge clk);
        chk("stall_wait", {31'd0, stall}, 32'd1);
        chk("mem_req_wait", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
      end
      mem_rvalid = 1'b1;
      mem_rdata = rdata;
      @(negedge clk);
      chk("stall_wait", {31'd0, stall}, 32'd1);
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
    end
    @(negedge clk);
    chk("rsp_valid_cycle", {31'd0, rsp_valid}, 32'd1);
    chk("stall_resp", {31'd0, stall}, 32'd0);
    chk("req_ready_resp", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rsp_valid_once", {31'd0, rsp_valid}, 32'd0);
    chk("req_ready_after", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // we size uns addr wdata gnt rv rdata be exp_wdata exp_rdata
    access(1'b1, 2'b10, 1'b0, 32'h13, 32'h000000AB, 0, 0, 32'h0, 4'b1000, 32'hABABABAB, 32'h0);
    access(1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 0, 1, 32'h12803456, 4'b0100, 32'h0, 32'hFFFFFF80);
    access(1'b0, 2'b10, 1'b1, 32'h02, 32'h0, 0, 1, 32'h12803456, 4'b0100, 32'h0, 32'h00000080);
    access(1'b0, 2'b01, 1'b0, 32'h06, 32'h0, 0, 1, 32'h9ABC1234, 4'b1100, 32'h0, 32'hFFFF9ABC);
    access(1'b1, 2'b01, 1'b0, 32'h06, 32'h00005555, 0, 0, 32'h0, 4'b1100, 32'h55555555, 32'h0);
    access(1'b0, 2'b01, 1'b1, 32'h00, 32'h0, 0, 1, 32'h00008001, 4'b0011, 32'h0, 32'h00008001);
    access(1'b0, 2'b01, 1'b0, 32'h00, 32'h0, 0, 1, 32'h00008001, 4'b0011, 32'h0, 32'hFFFF8001);
    access(1'b1, 2'b00, 1'b0, 32'h08, 32'h11223344, 0, 0, 32'h0, 4'b1111, 32'h11223344, 32'h0);
    access(1'b1, 2'b11, 1'b0, 32'h0C, 32'hA5A5_0F0F, 0, 0, 32'h0, 4'b1111, 32'hA5A50F0F, 32'h0);
    access(1'b0, 2'b00, 1'b0, 32'h40, 32'h0, 0, 0, 32'hDEADBEEF, 4'b1111, 32'h0, 32'hDEADBEEF);
    access(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 5, 4, 32'hCAFEF00D, 4'b1111, 32'h0, 32'hCAFEF00D);

    // Reset while waiting for read data, then a stray rvalid.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_addr = 32'h200;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    @(negedge clk);
    chk("wait_before_reset", {31'd0, stall}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h77777777;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("stray_rvalid_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("stray_rvalid_ready", {31'd0, req_ready}, 32'd1);
    access(1'b0, 2'b10, 1'b1, 32'h01, 32'h0, 0, 1, 32'h00007F00, 4'b0010, 32'h0, 32'h0000007F);

`ifdef MISALIGN_TRAP_EN
    begin
      rsp_t e;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h21;
      e.rdata = 32'd0; e.mis = 1'b1;
      sb_q.push_back(e);
      rsp_expected++;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("trap_rsp_cycle1", {31'd0, rsp_valid}, 32'd1);
      chk("trap_no_mem_req", {31'd0, mem_req}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("trap_rsp_once", {31'd0, rsp_valid}, 32'd0);
      chk("trap_no_mem_req2", {31'd0, mem_req}, 32'd0);
    end
`else
    access(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 0, 1, 32'h01020304, 4'b1111, 32'h0, 32'h01020304);
    access(1'b1, 2'b01, 1'b0, 32'h07, 32'h0000BEEF, 0, 0, 32'h0, 4'b1100, 32'hBEEFBEEF, 32'h0);
`endif

    @(posedge clk); #1;
    @(negedge clk);
    chk("rsp_count", rsp_seen, rsp_expected);
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
